// File: rtl/otter_pipe_pkg.sv
// Shared types and encodings for the OTTER pipeline sequencer.
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } seq_state_t;

    // EX-stage PC source encodings; anything other than PC4 is a taken redirect.
    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_JALR   = 2'd1;
    localparam logic [1:0] PCSRC_BRANCH = 2'd2;
    localparam logic [1:0] PCSRC_JAL    = 2'd3;

    localparam int unsigned DrainCntW = 3;

endpackage

// File: rtl/otter_load_use_detect.sv
// Combinational load-use hazard compare between ID/EX (load) and IF/ID (consumer).
module otter_load_use_detect (
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load to rd=0 cannot cause a stall.
    always_comb begin
        rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
        hazard_o = ex_memread_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/otter_pipe_sequencer.sv
// Pipeline controller: stage enables/flushes, hazard resolution and interrupt entry sequencing.
module otter_pipe_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        INTR,
    input  logic        MIE,
    input  logic        ID_VALID,
    input  logic [31:0] ID_PC,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_MEMREAD,
    input  logic [1:0]  EX_PCSOURCE,
    input  logic        MEM_BUSY,
    output logic        PC_WRITE,
    output logic        PC_SEL_TRAP,
    output logic        IF_ID_WRITE,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_WRITE,
    output logic        ID_EX_FLUSH,
    output logic        EX_MEM_WRITE,
    output logic        MEM_WB_WRITE,
    output logic        INTR_TAKEN,
    output logic [31:0] TRAP_EPC,
    output logic [31:0] STALL_COUNT
);
    import otter_pipe_pkg::*;

    localparam logic [DrainCntW-1:0] DrainLoad = DrainCntW'(DRAIN_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [DrainCntW-1:0] drain_cnt_q, drain_cnt_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          stall_cnt_q, stall_cnt_d;
    logic                 load_use;
    logic                 redirect;

    otter_load_use_detect u_load_use_detect (
        .ex_memread_i  (EX_MEMREAD),
        .ex_rd_i       (EX_RD),
        .id_rs1_i      (ID_RS1),
        .id_rs2_i      (ID_RS2),
        .id_uses_rs1_i (ID_USES_RS1),
        .id_uses_rs2_i (ID_USES_RS2),
        .hazard_o      (load_use)
    );

    assign redirect = (EX_PCSOURCE != PCSRC_PC4);

    // Next-state and stage-control decode; outputs are combinational from state and inputs.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        epc_d        = epc_q;
        PC_WRITE     = 1'b1;
        PC_SEL_TRAP  = 1'b0;
        IF_ID_WRITE  = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_WRITE  = 1'b1;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_WRITE = 1'b1;
        MEM_WB_WRITE = 1'b1;
        INTR_TAKEN   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (MEM_BUSY) begin
                    PC_WRITE     = 1'b0;
                    IF_ID_WRITE  = 1'b0;
                    ID_EX_WRITE  = 1'b0;
                    EX_MEM_WRITE = 1'b0;
                    MEM_WB_WRITE = 1'b0;
                end else if (redirect) begin
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end else if (load_use) begin
                    PC_WRITE    = 1'b0;
                    IF_ID_WRITE = 1'b0;
                    ID_EX_FLUSH = 1'b1;
                end else if (INTR && MIE && ID_VALID) begin
                    // The instruction in IF/ID is squashed and becomes the return point.
                    PC_WRITE    = 1'b0;
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    epc_d       = ID_PC;
                    drain_cnt_d = DrainLoad;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                PC_WRITE = 1'b0;
                if (MEM_BUSY) begin
                    IF_ID_WRITE  = 1'b0;
                    ID_EX_WRITE  = 1'b0;
                    EX_MEM_WRITE = 1'b0;
                    MEM_WB_WRITE = 1'b0;
                end else begin
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    if (drain_cnt_q == '0) begin
                        state_d = TRAP;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
            end
            TRAP: begin
                PC_SEL_TRAP = 1'b1;
                if (MEM_BUSY) begin
                    PC_WRITE     = 1'b0;
                    IF_ID_WRITE  = 1'b0;
                    ID_EX_WRITE  = 1'b0;
                    EX_MEM_WRITE = 1'b0;
                    MEM_WB_WRITE = 1'b0;
                end else begin
                    INTR_TAKEN  = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (RESET) begin
            PC_SEL_TRAP = 1'b0;
            INTR_TAKEN  = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!PC_WRITE && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State, drain counter, EPC and stall counter registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            epc_q       <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            epc_q       <= epc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign TRAP_EPC    = epc_q;
    assign STALL_COUNT = stall_cnt_q;

endmodule
